clk_meter: RTL and testbench

- Receive-side counterpart to the clock-enable splitter.
- Takes a periodic strobe or divided-clock signal and measures its period and high time in `clk` cycles.
- Reports each completed period with a one-cycle valid pulse, flags loss of signal, and asserts `locked_o` once the period is stable.
- Used to check generated enables and to measure external reference clocks.

---
 rtl/clk_meter.sv | 136 +++++++++++++
 tb/tb_clk_meter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_meter.sv
// Measures period and high time of a strobe/divided clock in clk cycles, with lock and timeout.
// Optional input synchronizer enabled by defining CLK_METER_SYNC_EN.
module clk_meter #(
  parameter int unsigned MAX_T  = 50000000,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned TOL    = 0,
  localparam int unsigned W     = $clog2(MAX_T + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         sig_i,
  output logic         valid_o,
  output logic [W-1:0] period_o,
  output logic [W-1:0] high_o,
  output logic         locked_o,
  output logic         timeout_o
);

  localparam int unsigned MW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {SEEK, RUN, TOUT} state_t;

  state_t          r_state;
  logic            r_s_d;
  logic [W-1:0]    r_cnt;
  logic [W-1:0]    r_hcnt;
  logic [W-1:0]    r_prev;
  logic            r_have_prev;
  logic [MW-1:0]   r_match;

  logic            w_s;
  logic            w_edge;
  logic [W:0]      w_diff;
  logic            w_match;
  logic [MW-1:0]   w_match_inc;

`ifdef CLK_METER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], sig_i};
  end

  assign w_s = r_sync[1];
`else
  assign w_s = sig_i;
`endif

  assign w_edge = w_s & ~r_s_d;

  // Absolute period difference at W+1 bits so it can never wrap.
  always_comb begin
    w_diff = '0;
    if (r_cnt >= r_prev) w_diff = {1'b0, r_cnt} - {1'b0, r_prev};
    else                 w_diff = {1'b0, r_prev} - {1'b0, r_cnt};
  end

  assign w_match     = (w_diff <= (W+1)'(TOL));
  assign w_match_inc = (r_match == MW'(LOCK_N)) ? r_match : r_match + MW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEEK;
      r_s_d       <= 1'b0;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_match     <= '0;
      valid_o     <= 1'b0;
      period_o    <= '0;
      high_o      <= '0;
      locked_o    <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      r_s_d   <= w_s;
      valid_o <= 1'b0;
      if (!ena) begin
        r_state     <= SEEK;
        r_cnt       <= '0;
        r_hcnt      <= '0;
        r_have_prev <= 1'b0;
        r_match     <= '0;
        locked_o    <= 1'b0;
        timeout_o   <= 1'b0;
      end else begin
        case (r_state)
          SEEK, TOUT: begin
            // First edge only arms the counters; nothing to report yet.
            if (w_edge) begin
              r_state   <= RUN;
              r_cnt     <= W'(1);
              r_hcnt    <= W'(1);
              timeout_o <= 1'b0;
            end
          end
          RUN: begin
            if (w_edge) begin
              period_o    <= r_cnt;
              high_o      <= r_hcnt;
              valid_o     <= 1'b1;
              r_prev      <= r_cnt;
              r_have_prev <= 1'b1;
              r_cnt       <= W'(1);
              r_hcnt      <= W'(1);
              if (r_have_prev) begin
                if (w_match) begin
                  r_match  <= w_match_inc;
                  locked_o <= (w_match_inc == MW'(LOCK_N));
                end else begin
                  r_match  <= '0;
                  locked_o <= 1'b0;
                end
              end
            end else if (r_cnt == W'(MAX_T)) begin
              r_state     <= TOUT;
              r_cnt       <= '0;
              r_hcnt      <= '0;
              r_have_prev <= 1'b0;
              r_match     <= '0;
              locked_o    <= 1'b0;
              timeout_o   <= 1'b1;
            end else begin
              r_cnt  <= r_cnt + W'(1);
              r_hcnt <= r_hcnt + W'(w_s);
            end
          end
          default: r_state <= SEEK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Directed bench for clk_meter: reset, lock, tolerance, timeout, min/max period, ena and reset recovery.
module tb_clk_meter;

  localparam int unsigned MAX_T  = 64;
  localparam int unsigned LOCK_N = 4;
  localparam int unsigned TOL    = 1;
  localparam int unsigned W      = $clog2(MAX_T + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         sig_i = 1'b0;
  logic         valid_o;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         locked_o;
  logic         timeout_o;

  int total = 0;
  int bad   = 0;

  logic         ob_v, ob_lk, ob_to;
  logic [W-1:0] ob_p, ob_h;
  int           ob_extra;

  clk_meter #(.MAX_T(MAX_T), .LOCK_N(LOCK_N), .TOL(TOL)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sig_i(sig_i),
    .valid_o(valid_o), .period_o(period_o), .high_o(high_o),
    .locked_o(locked_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic v);
    sig_i = v;
    @(posedge clk);
    #1;
  endtask

  // One signal period starting with its rising edge; captures outputs right after the edge cycle.
  task automatic pulse(input int hi, input int lo);
    tick(1'b1);
    ob_v = valid_o; ob_p = period_o; ob_h = high_o; ob_lk = locked_o; ob_to = timeout_o;
    ob_extra = 0;
    for (int i = 1; i < hi; i++) begin tick(1'b1); if (valid_o) ob_extra++; end
    for (int i = 0; i < lo; i++) begin tick(1'b0); if (valid_o) ob_extra++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'(i % 2));
      total++;
      if ({valid_o, period_o, high_o, locked_o, timeout_o} !== '0) begin
        bad++;
        $display("FAIL reset_%0d: got v=%b p=%0d h=%0d lk=%b to=%b, want all 0",
                 i, valid_o, period_o, high_o, locked_o, timeout_o);
      end
    end
    rst = 1'b0;
    tick(1'b0);
    pulse(5, 5);
    total++;
    if (ob_v !== 1'b0 || ob_extra != 0) begin
      bad++;
      $display("FAIL reset_first_edge: got v=%b extra=%0d, want v=0 extra=0", ob_v, ob_extra);
    end
  endtask

  task automatic test_lock();
    for (int k = 1; k <= 5; k++) begin
      pulse(5, 5);
      total++;
      if ({ob_v, ob_p, ob_h, ob_lk, ob_to} !== {1'b1, W'(10), W'(5), (k == 5), 1'b0} || ob_extra != 0) begin
        bad++;
        $display("FAIL lock_%0d: got v=%b p=%0d h=%0d lk=%b to=%b extra=%0d, want v=1 p=10 h=5 lk=%0d to=0",
                 k, ob_v, ob_p, ob_h, ob_lk, ob_to, ob_extra, (k == 5));
      end
    end
  endtask

  task automatic test_tol();
    pulse(5, 6);
    total++;
    if ({ob_v, ob_p, ob_lk} !== {1'b1, W'(10), 1'b1}) begin
      bad++;
      $display("FAIL tol_10: got v=%b p=%0d lk=%b, want v=1 p=10 lk=1", ob_v, ob_p, ob_lk);
    end
    pulse(5, 8);
    total++;
    if ({ob_v, ob_p, ob_h, ob_lk} !== {1'b1, W'(11), W'(5), 1'b1}) begin
      bad++;
      $display("FAIL tol_11: got v=%b p=%0d h=%0d lk=%b, want v=1 p=11 h=5 lk=1", ob_v, ob_p, ob_h, ob_lk);
    end
    pulse(5, 5);
    total++;
    if ({ob_v, ob_p, ob_h, ob_lk} !== {1'b1, W'(13), W'(5), 1'b0}) begin
      bad++;
      $display("FAIL tol_13: got v=%b p=%0d h=%0d lk=%b, want v=1 p=13 h=5 lk=0", ob_v, ob_p, ob_h, ob_lk);
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 5; k++) pulse(5, 5);
    total++;
    if (ob_lk !== 1'b1) begin
      bad++;
      $display("FAIL timeout_prelock: got lk=%b, want 1", ob_lk);
    end
    // pulse already spent 9 cycles after the edge; 54 more reach 63.
    for (int j = 10; j < 64; j++) tick(1'b0);
    total++;
    if (timeout_o !== 1'b0 || locked_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got to=%b lk=%b, want to=0 lk=1", timeout_o, locked_o);
    end
    tick(1'b0);
    total++;
    if ({timeout_o, locked_o, valid_o, period_o} !== {1'b1, 1'b0, 1'b0, W'(10)}) begin
      bad++;
      $display("FAIL timeout_at_65: got to=%b lk=%b v=%b p=%0d, want to=1 lk=0 v=0 p=10",
               timeout_o, locked_o, valid_o, period_o);
    end
    pulse(3, 3);
    total++;
    if (ob_v !== 1'b0 || ob_to !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rearm: got v=%b to=%b, want v=0 to=0", ob_v, ob_to);
    end
    pulse(3, 3);
    total++;
    if ({ob_v, ob_p, ob_h, ob_lk, ob_to} !== {1'b1, W'(6), W'(3), 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL timeout_resume: got v=%b p=%0d h=%0d lk=%b to=%b, want v=1 p=6 h=3 lk=0 to=0",
               ob_v, ob_p, ob_h, ob_lk, ob_to);
    end
  endtask

  task automatic test_min_period();
    pulse(1, 1);
    pulse(1, 1);
    total++;
    if ({ob_v, ob_p, ob_h} !== {1'b1, W'(2), W'(1)}) begin
      bad++;
      $display("FAIL min_period: got v=%b p=%0d h=%0d, want v=1 p=2 h=1", ob_v, ob_p, ob_h);
    end
  endtask

  task automatic test_max_period();
    pulse(1, 63);
    total++;
    if ({ob_v, ob_p, ob_h} !== {1'b1, W'(2), W'(1)}) begin
      bad++;
      $display("FAIL max_pre: got v=%b p=%0d h=%0d, want v=1 p=2 h=1", ob_v, ob_p, ob_h);
    end
    pulse(1, 64);
    total++;
    if ({ob_v, ob_p, ob_h, ob_to} !== {1'b1, W'(64), W'(1), 1'b0}) begin
      bad++;
      $display("FAIL max_exact: got v=%b p=%0d h=%0d to=%b, want v=1 p=64 h=1 to=0", ob_v, ob_p, ob_h, ob_to);
    end
    total++;
    if (timeout_o !== 1'b1 || ob_extra != 0) begin
      bad++;
      $display("FAIL max_plus1: got to=%b extra=%0d, want to=1 extra=0", timeout_o, ob_extra);
    end
    pulse(2, 2);
    total++;
    if (ob_v !== 1'b0 || ob_to !== 1'b0) begin
      bad++;
      $display("FAIL max_rearm: got v=%b to=%b, want v=0 to=0", ob_v, ob_to);
    end
    pulse(2, 2);
    total++;
    if ({ob_v, ob_p, ob_h} !== {1'b1, W'(4), W'(2)}) begin
      bad++;
      $display("FAIL max_resume: got v=%b p=%0d h=%0d, want v=1 p=4 h=2", ob_v, ob_p, ob_h);
    end
  endtask

  task automatic test_ena_drop();
    for (int k = 0; k < 6; k++) pulse(5, 5);
    total++;
    if (ob_lk !== 1'b1) begin
      bad++;
      $display("FAIL ena_prelock: got lk=%b, want 1", ob_lk);
    end
    tick(1'b1);
    tick(1'b1);
    ena = 1'b0;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    total++;
    if ({locked_o, timeout_o, valid_o, period_o} !== {1'b0, 1'b0, 1'b0, W'(10)}) begin
      bad++;
      $display("FAIL ena_off: got lk=%b to=%b v=%b p=%0d, want lk=0 to=0 v=0 p=10",
               locked_o, timeout_o, valid_o, period_o);
    end
    ena = 1'b1;
    tick(1'b0);
    tick(1'b0);
    pulse(5, 5);
    total++;
    if (ob_v !== 1'b0 || ob_extra != 0) begin
      bad++;
      $display("FAIL ena_rearm: got v=%b extra=%0d, want v=0 extra=0", ob_v, ob_extra);
    end
    pulse(5, 5);
    total++;
    if ({ob_v, ob_p, ob_h, ob_lk} !== {1'b1, W'(10), W'(5), 1'b0}) begin
      bad++;
      $display("FAIL ena_resume: got v=%b p=%0d h=%0d lk=%b, want v=1 p=10 h=5 lk=0", ob_v, ob_p, ob_h, ob_lk);
    end
  endtask

  task automatic test_rst_mid();
    tick(1'b1);
    tick(1'b1);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({valid_o, period_o, high_o, locked_o, timeout_o} !== '0) begin
      bad++;
      $display("FAIL rst_async: got v=%b p=%0d h=%0d lk=%b to=%b, want all 0",
               valid_o, period_o, high_o, locked_o, timeout_o);
    end
    tick(1'b0);
    tick(1'b1);
    rst = 1'b0;
    tick(1'b0);
    pulse(5, 5);
    total++;
    if (ob_v !== 1'b0 || ob_extra != 0) begin
      bad++;
      $display("FAIL rst_rearm: got v=%b extra=%0d, want v=0 extra=0", ob_v, ob_extra);
    end
    pulse(5, 5);
    total++;
    if ({ob_v, ob_p, ob_h, ob_lk} !== {1'b1, W'(10), W'(5), 1'b0}) begin
      bad++;
      $display("FAIL rst_resume: got v=%b p=%0d h=%0d lk=%b, want v=1 p=10 h=5 lk=0", ob_v, ob_p, ob_h, ob_lk);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tol();
    test_timeout();
    test_min_period();
    test_max_period();
    test_ena_drop();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
